// File: rtl/mips_pipe_pkg.sv
// ---------------------------------------------------------------------------
// mips_pipe_pkg
// Shared definitions for the 5-stage MIPS pipeline control logic.
//   FWD_*    : encodings of the EX operand source select
//   REG_ZERO : architectural $zero, never a forwarding/hazard source
//   fwdSel   : picks the forwarding source for one EX operand
// ---------------------------------------------------------------------------
package mips_pipe_pkg;

    localparam logic [1:0] FWD_RF   = 2'b00;
    localparam logic [1:0] FWD_WB   = 2'b01;
    localparam logic [1:0] FWD_MEM  = 2'b10;
    localparam logic [4:0] REG_ZERO = 5'd0;

    // The MEM result is younger than the WB result, so it wins when both
    // stages target the same register.
    function automatic logic [1:0] fwdSel(
        input logic [4:0] src,
        input logic       wrMem,
        input logic [4:0] destMem,
        input logic       wrWb,
        input logic [4:0] destWb
    );
        logic [1:0] sel;
        sel = FWD_RF;
        if (wrMem && (destMem != REG_ZERO) && (destMem == src)) begin
            sel = FWD_MEM;
        end else if (wrWb && (destWb != REG_ZERO) && (destWb == src)) begin
            sel = FWD_WB;
        end
        return sel;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at all-ones instead of wrapping.
//   clk     : clock
//   reset   : asynchronous, active-high clear
//   i_inc   : count one event on this edge
//   o_count : current count
// ---------------------------------------------------------------------------
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_inc,
    output logic [W-1:0] o_count
);

    logic [W-1:0] r_count;

    // Count events, holding once the counter is full.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_inc && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
// Hazard controller for the 5-stage MIPS pipeline.
//   Inputs : register specifiers and control bits from ID, EX, MEM and WB,
//            plus the mul/div issue and taken-branch strobes from EX.
//   Outputs: stall_if_o/stall_id_o hold the front end, clr_id_o/clr_ex_o
//            flush IF-ID / ID-EX, fwd_a_o/fwd_b_o select EX operand sources,
//            md_busy_o flags the mul/div unit as occupied, stall_cnt_o and
//            flush_cnt_o are saturating statistics.
// ---------------------------------------------------------------------------
module hazard_ctrl
    import mips_pipe_pkg::*;
#(
    parameter int MD_LAT = 4,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       rs_id_i,
    input  logic [4:0]       rt_id_i,
    input  logic             hilo_use_id_i,
    input  logic             valid_id_i,
    input  logic [4:0]       rs_ex_i,
    input  logic [4:0]       rt_ex_i,
    input  logic [4:0]       dest_ex_i,
    input  logic             reg_wr_ex_i,
    input  logic             mem_to_reg_ex_i,
    input  logic             md_start_ex_i,
    input  logic             branch_taken_ex_i,
    input  logic [4:0]       dest_mem_i,
    input  logic             reg_wr_mem_i,
    input  logic [4:0]       dest_wb_i,
    input  logic             reg_wr_wb_i,
    output logic             stall_if_o,
    output logic             stall_id_o,
    output logic             clr_id_o,
    output logic             clr_ex_o,
    output logic [1:0]       fwd_a_o,
    output logic [1:0]       fwd_b_o,
    output logic             md_busy_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    localparam logic [3:0] MD_RELOAD = 4'(MD_LAT - 1);

    logic [3:0] r_mdCnt;
    logic       w_loadUse;
    logic       w_mdHazard;

    // Remaining cycles the HI/LO unit stays occupied after the issuing edge.
    // A new issue always reloads, even if the unit is still busy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mdCnt <= 4'd0;
        end else if (md_start_ex_i) begin
            r_mdCnt <= MD_RELOAD;
        end else if (r_mdCnt != 4'd0) begin
            r_mdCnt <= r_mdCnt - 4'd1;
        end
    end

    assign md_busy_o = (r_mdCnt != 4'd0);

    // The op issuing in EX this cycle already blocks HI/LO users in ID.
    assign w_loadUse  = valid_id_i && reg_wr_ex_i && mem_to_reg_ex_i &&
                        (dest_ex_i != REG_ZERO) &&
                        ((dest_ex_i == rs_id_i) || (dest_ex_i == rt_id_i));
    assign w_mdHazard = valid_id_i && hilo_use_id_i && (md_busy_o || md_start_ex_i);

    // Control outputs are held quiet during reset. A taken branch squashes
    // the ID instruction, so its flush overrides any stall that instruction
    // would otherwise cause.
    always_comb begin
        stall_if_o = 1'b0;
        stall_id_o = 1'b0;
        clr_id_o   = 1'b0;
        clr_ex_o   = 1'b0;
        fwd_a_o    = FWD_RF;
        fwd_b_o    = FWD_RF;
        if (!reset) begin
            fwd_a_o = fwdSel(rs_ex_i, reg_wr_mem_i, dest_mem_i, reg_wr_wb_i, dest_wb_i);
            fwd_b_o = fwdSel(rt_ex_i, reg_wr_mem_i, dest_mem_i, reg_wr_wb_i, dest_wb_i);
            if (branch_taken_ex_i) begin
                clr_id_o = 1'b1;
                clr_ex_o = 1'b1;
            end else if (w_loadUse || w_mdHazard) begin
                stall_if_o = 1'b1;
                stall_id_o = 1'b1;
                clr_ex_o   = 1'b1;
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_stallCnt (
        .clk     (clk),
        .reset   (reset),
        .i_inc   (stall_id_o),
        .o_count (stall_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_flushCnt (
        .clk     (clk),
        .reset   (reset),
        .i_inc   (branch_taken_ex_i),
        .o_count (flush_cnt_o)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_ctrl
// Self-checking bench for hazard_ctrl, built with MD_LAT=4 and CNT_W=4 so
// counter saturation is reachable quickly.
// ---------------------------------------------------------------------------
module tb_hazard_ctrl;

    localparam int MD_LAT  = 4;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk;
    logic             reset;
    logic [4:0]       rs_id_i, rt_id_i, rs_ex_i, rt_ex_i;
    logic [4:0]       dest_ex_i, dest_mem_i, dest_wb_i;
    logic             hilo_use_id_i, valid_id_i, reg_wr_ex_i, mem_to_reg_ex_i;
    logic             md_start_ex_i, branch_taken_ex_i, reg_wr_mem_i, reg_wr_wb_i;
    logic             stall_if_o, stall_id_o, clr_id_o, clr_ex_o, md_busy_o;
    logic [1:0]       fwd_a_o, fwd_b_o;
    logic [CNT_W-1:0] stall_cnt_o, flush_cnt_o;

    int checkCount = 0;
    int failCount  = 0;

    // Reference state: cycles of HI/LO occupancy left, and event totals.
    int mdLeft     = 0;
    int stallTotal = 0;
    int flushTotal = 0;

    hazard_ctrl #(.MD_LAT(MD_LAT), .CNT_W(CNT_W)) dut (
        .clk               (clk),
        .reset             (reset),
        .rs_id_i           (rs_id_i),
        .rt_id_i           (rt_id_i),
        .hilo_use_id_i     (hilo_use_id_i),
        .valid_id_i        (valid_id_i),
        .rs_ex_i           (rs_ex_i),
        .rt_ex_i           (rt_ex_i),
        .dest_ex_i         (dest_ex_i),
        .reg_wr_ex_i       (reg_wr_ex_i),
        .mem_to_reg_ex_i   (mem_to_reg_ex_i),
        .md_start_ex_i     (md_start_ex_i),
        .branch_taken_ex_i (branch_taken_ex_i),
        .dest_mem_i        (dest_mem_i),
        .reg_wr_mem_i      (reg_wr_mem_i),
        .dest_wb_i         (dest_wb_i),
        .reg_wr_wb_i       (reg_wr_wb_i),
        .stall_if_o        (stall_if_o),
        .stall_id_o        (stall_id_o),
        .clr_id_o          (clr_id_o),
        .clr_ex_o          (clr_ex_o),
        .fwd_a_o           (fwd_a_o),
        .fwd_b_o           (fwd_b_o),
        .md_busy_o         (md_busy_o),
        .stall_cnt_o       (stall_cnt_o),
        .flush_cnt_o       (flush_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Forwarding source as the pipeline would describe it: youngest writer wins.
    function automatic int refFwd(input logic [4:0] src);
        if (reg_wr_mem_i && dest_mem_i != 0 && dest_mem_i == src) return 2;
        if (reg_wr_wb_i && dest_wb_i != 0 && dest_wb_i == src) return 1;
        return 0;
    endfunction

    function automatic bit refStall();
        bit loadUse, mdHaz;
        loadUse = valid_id_i && reg_wr_ex_i && mem_to_reg_ex_i && dest_ex_i != 0 &&
                  (dest_ex_i == rs_id_i || dest_ex_i == rt_id_i);
        mdHaz   = valid_id_i && hilo_use_id_i && (mdLeft > 0 || md_start_ex_i);
        return !branch_taken_ex_i && (loadUse || mdHaz);
    endfunction

    task automatic clearInputs();
        rs_id_i = 0; rt_id_i = 0; rs_ex_i = 0; rt_ex_i = 0;
        dest_ex_i = 0; dest_mem_i = 0; dest_wb_i = 0;
        hilo_use_id_i = 0; valid_id_i = 0; reg_wr_ex_i = 0; mem_to_reg_ex_i = 0;
        md_start_ex_i = 0; branch_taken_ex_i = 0; reg_wr_mem_i = 0; reg_wr_wb_i = 0;
    endtask

    task automatic checkAll(input string tag);
        bit stallExp;
        stallExp = refStall();
        checkOutput({tag, ".stall_if"}, 32'(stall_if_o), 32'(stallExp));
        checkOutput({tag, ".stall_id"}, 32'(stall_id_o), 32'(stallExp));
        checkOutput({tag, ".clr_id"},   32'(clr_id_o),   32'(branch_taken_ex_i));
        checkOutput({tag, ".clr_ex"},   32'(clr_ex_o),   32'(stallExp || branch_taken_ex_i));
        checkOutput({tag, ".fwd_a"},    32'(fwd_a_o),    32'(refFwd(rs_ex_i)));
        checkOutput({tag, ".fwd_b"},    32'(fwd_b_o),    32'(refFwd(rt_ex_i)));
        checkOutput({tag, ".md_busy"},  32'(md_busy_o),  32'(mdLeft > 0));
        checkOutput({tag, ".stall_cnt"}, 32'(stall_cnt_o), 32'(stallTotal));
        checkOutput({tag, ".flush_cnt"}, 32'(flush_cnt_o), 32'(flushTotal));
    endtask

    // Inputs are already driven (just after a falling edge): check, clock,
    // advance the reference, and return at the next falling edge.
    task automatic applyStimulus(input string tag);
        bit stallNow;
        #1;
        checkAll(tag);
        stallNow = refStall();
        @(posedge clk);
        if (stallNow && stallTotal < CNT_MAX) stallTotal++;
        if (branch_taken_ex_i && flushTotal < CNT_MAX) flushTotal++;
        if (md_start_ex_i) mdLeft = MD_LAT - 1;
        else if (mdLeft > 0) mdLeft--;
        @(negedge clk);
    endtask

    task automatic setLoadUse(input logic [4:0] r);
        valid_id_i = 1; reg_wr_ex_i = 1; mem_to_reg_ex_i = 1; dest_ex_i = r; rs_id_i = r;
    endtask

    task automatic resetModel();
        mdLeft = 0; stallTotal = 0; flushTotal = 0;
    endtask

    initial begin
        // Reset with every hazard and forwarding condition active.
        clearInputs();
        reset = 1;
        setLoadUse(5'd5);
        branch_taken_ex_i = 1;
        rs_ex_i = 3; rt_ex_i = 3; dest_mem_i = 3; reg_wr_mem_i = 1;
        #2;
        checkOutput("rst.stall_if", 32'(stall_if_o), 0);
        checkOutput("rst.clr_id",   32'(clr_id_o), 0);
        checkOutput("rst.clr_ex",   32'(clr_ex_o), 0);
        checkOutput("rst.fwd_a",    32'(fwd_a_o), 0);
        checkOutput("rst.md_busy",  32'(md_busy_o), 0);
        checkOutput("rst.stall_cnt", 32'(stall_cnt_o), 0);
        @(negedge clk);
        @(negedge clk);
        reset = 0;
        clearInputs();

        // Load-use: one bubble, then the load has moved on.
        setLoadUse(5'd5);
        applyStimulus("lu");
        clearInputs();
        applyStimulus("lu_after");
        checkOutput("lu.stall_cnt_one", 32'(stall_cnt_o), 1);

        // Forwarding priority and $zero exclusion.
        rs_ex_i = 3; dest_mem_i = 3; dest_wb_i = 3; reg_wr_mem_i = 1; reg_wr_wb_i = 1;
        applyStimulus("fwd_mem");
        checkOutput("fwd_mem.const", 32'(fwd_a_o), 2);
        reg_wr_mem_i = 0;
        applyStimulus("fwd_wb");
        reg_wr_mem_i = 1; dest_mem_i = 0; dest_wb_i = 0; rs_ex_i = 0;
        applyStimulus("fwd_zero");
        clearInputs();

        // Mul/div issue followed by mflo in ID every cycle.
        md_start_ex_i = 1; valid_id_i = 1; hilo_use_id_i = 1;
        applyStimulus("md_start");
        md_start_ex_i = 0;
        for (int i = 0; i < 5; i++) applyStimulus("md_busy");
        checkOutput("md.stall_total", 32'(stall_cnt_o), 5);
        clearInputs();

        // Taken branch overrides a concurrent load-use.
        setLoadUse(5'd7);
        branch_taken_ex_i = 1;
        applyStimulus("br_lu");
        clearInputs();
        applyStimulus("br_after");
        checkOutput("br.flush_cnt", 32'(flush_cnt_o), 1);

        // Saturation: 21 consecutive stall cycles.
        setLoadUse(5'd9);
        for (int i = 0; i < 21; i++) applyStimulus("sat");
        clearInputs();
        applyStimulus("sat_hold");
        checkOutput("sat.stall_cnt", 32'(stall_cnt_o), 32'hF);

        // Async reset while the mul/div counter sits at 2.
        md_start_ex_i = 1;
        applyStimulus("ar_start");
        md_start_ex_i = 0;
        applyStimulus("ar_busy");
        setLoadUse(5'd4);
        branch_taken_ex_i = 1;
        #2;
        reset = 1;
        #1;
        checkOutput("ar.md_busy",   32'(md_busy_o), 0);
        checkOutput("ar.stall_cnt", 32'(stall_cnt_o), 0);
        checkOutput("ar.flush_cnt", 32'(flush_cnt_o), 0);
        checkOutput("ar.clr_ex",    32'(clr_ex_o), 0);
        checkOutput("ar.clr_id",    32'(clr_id_o), 0);
        resetModel();
        @(negedge clk);
        reset = 0;
        clearInputs();
        md_start_ex_i = 1; valid_id_i = 1; hilo_use_id_i = 1;
        applyStimulus("ar_md_start");
        md_start_ex_i = 0;
        for (int i = 0; i < 4; i++) applyStimulus("ar_md_busy");
        clearInputs();

        // Randomized traffic on a small register range to provoke matches.
        for (int i = 0; i < 300; i++) begin
            rs_id_i = 5'($urandom_range(0, 3));
            rt_id_i = 5'($urandom_range(0, 3));
            rs_ex_i = 5'($urandom_range(0, 3));
            rt_ex_i = 5'($urandom_range(0, 3));
            dest_ex_i  = 5'($urandom_range(0, 3));
            dest_mem_i = 5'($urandom_range(0, 3));
            dest_wb_i  = 5'($urandom_range(0, 3));
            valid_id_i      = 1'($urandom_range(0, 3) != 0);
            hilo_use_id_i   = 1'($urandom_range(0, 2) == 0);
            reg_wr_ex_i     = 1'($urandom);
            mem_to_reg_ex_i = 1'($urandom);
            reg_wr_mem_i    = 1'($urandom);
            reg_wr_wb_i     = 1'($urandom);
            md_start_ex_i     = 1'($urandom_range(0, 7) == 0);
            branch_taken_ex_i = 1'($urandom_range(0, 5) == 0);
            applyStimulus("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
